mem_request_master: RTL

Cache-side initiator for the main-memory port. Accepts one request at a time from the cache controller: a single-word write-through store, or a 4-word line fill on a read miss. It drives the main memory's address, read_en, write_en and write_data signals, and waits for the memory's ready handshake. It then returns the captured 128-bit line, or a write acknowledge, to the controller with a one-cycle response pulse.

---
 rtl/mem_request_master_if.sv | 31 +++
 rtl/mem_request_master.sv | 79 +++++++
 2 files changed

// File: rtl/mem_request_master_if.sv
// mem_request_master_if: controller request/response and main-memory port bundle
interface mem_request_master_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);
  logic                 req_valid;
  logic                 req_write;
  logic [ADDR_W-1:0]    req_addr;
  logic [WIDTH-1:0]     req_wdata;
  logic                 req_ready;
  logic                 resp_valid;
  logic                 resp_write;
  logic                 resp_err;
  logic [4*WIDTH-1:0]   resp_line;
  logic [ADDR_W-1:0]    mem_address;
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [WIDTH-1:0]     mem_write_data;
  logic                 mem_ready;
  logic [4*WIDTH-1:0]   mem_read_data;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_ready, mem_read_data,
    output req_ready, resp_valid, resp_write, resp_err, resp_line,
           mem_address, mem_read_en, mem_write_en, mem_write_data
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_ready, mem_read_data,
    input  req_ready, resp_valid, resp_write, resp_err, resp_line,
           mem_address, mem_read_en, mem_write_en, mem_write_data
  );
endinterface

// File: rtl/mem_request_master.sv
// mem_request_master: single-outstanding word-write / line-fill initiator for main memory
module mem_request_master #(
  parameter  int WIDTH   = 32,
  parameter  int DEPTH   = 1024,
  parameter  int TIMEOUT = 16,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  reset,
  mem_request_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t               state_q;
  logic [7:0]           cnt_q, cnt_d;
  logic                 req_ready_q, resp_valid_q, resp_write_q, resp_err_q;
  logic [4*WIDTH-1:0]   resp_line_q;
  logic [ADDR_W-1:0]    mem_address_q;
  logic                 mem_read_en_q, mem_write_en_q;
  logic [WIDTH-1:0]     mem_write_data_q;
  logic                 done_ok, tmo;
  assign cnt_d   = cnt_q + 8'd1;
  // the issue cycle (cnt_q == 0) may see a stale mem_ready from the previous access
  assign done_ok = bus.mem_ready && |cnt_q;
  assign tmo     = cnt_d == 8'(TIMEOUT);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_write_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_line_q      <= '0;
      mem_address_q    <= '0;
      mem_read_en_q    <= 1'b0;
      mem_write_en_q   <= 1'b0;
      mem_write_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          req_ready_q    <= 1'b0;
          cnt_q          <= '0;
          mem_address_q  <= bus.req_write ? bus.req_addr : {bus.req_addr[ADDR_W-1:2], 2'b00};
          mem_write_en_q <= bus.req_write;
          mem_read_en_q  <= !bus.req_write;
          if (bus.req_write) mem_write_data_q <= bus.req_wdata;
          state_q        <= bus.req_write ? WR : RD;
        end
        RD, WR: begin
          cnt_q <= cnt_d;
          if (done_ok || tmo) begin
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            resp_valid_q   <= 1'b1;
            resp_write_q   <= state_q == WR;
            resp_err_q     <= !done_ok;
            if (state_q == RD || !done_ok) resp_line_q <= done_ok ? bus.mem_read_data : '0;
            state_q        <= DONE;
          end
        end
        DONE: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_write     = resp_write_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.resp_line      = resp_line_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_read_en    = mem_read_en_q;
  assign bus.mem_write_en   = mem_write_en_q;
  assign bus.mem_write_data = mem_write_data_q;
endmodule
